// File: rtl/piso_bit_source_if.sv
// rtl/piso_bit_source_if.sv - load/ready word input and serial bit output bundle for piso_bit_source
interface piso_bit_source_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;
  logic             x;
  logic             bit_valid;
  logic             last;

  modport master (
    output din,
    output load,
    input  ready,
    input  x,
    input  bit_valid,
    input  last
  );

  modport slave (
    input  din,
    input  load,
    output ready,
    output x,
    output bit_valid,
    output last
  );
endinterface

// File: rtl/piso_bit_source.sv
// rtl/piso_bit_source.sv - parallel-in/serial-out bit source for the 1010 detector x input
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
module piso_bit_source #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  piso_bit_source_if.slave   bus
);

`ifdef PISO_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CW = $clog2(FLEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FLEN);
`ifdef PISO_PARITY_EN
  localparam logic [CW-1:0] DATA_CNT = CW'(WIDTH);
`endif

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif
  logic             ready;
  logic             accept;

  // The final-bit cycle also accepts a word, which is what makes frames gapless.
  assign ready  = (state_q == ST_IDLE) || ((state_q == ST_SHIFT) && last_q);
  assign accept = bus.load && ready;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    valid_d  = valid_q;
    last_d   = last_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    if (accept) begin
      state_d = ST_SHIFT;
      cnt_d   = CW'(1);
      valid_d = 1'b1;
      last_d  = 1'b0;
`ifdef PISO_PARITY_EN
      parity_d = ^bus.din;
`endif
      // The first bit leaves immediately; the register keeps only the remainder.
      if (MSB_FIRST) begin
        x_d     = bus.din[WIDTH-1];
        shreg_d = bus.din << 1;
      end else begin
        x_d     = bus.din[0];
        shreg_d = bus.din >> 1;
      end
    end else if (state_q == ST_SHIFT) begin
      if (last_q) begin
        state_d = ST_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
        x_d     = IDLE_LEVEL;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        cnt_d  = cnt_q + CW'(1);
        last_d = ((cnt_q + CW'(1)) == LAST_CNT);
`ifdef PISO_PARITY_EN
        if (cnt_q == DATA_CNT) begin
          x_d = parity_q;
        end else
`endif
        if (MSB_FIRST) begin
          x_d     = shreg_q[WIDTH-1];
          shreg_d = shreg_q << 1;
        end else begin
          x_d     = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      x_q      <= IDLE_LEVEL;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.ready     = ready;
  assign bus.x         = x_q;
  assign bus.bit_valid = valid_q;
  assign bus.last      = last_q;

endmodule

// File: tb/tb_piso_bit_source.sv
// tb/tb_piso_bit_source.sv - scoreboard bench for piso_bit_source (MSB-first and LSB-first instances)
module tb_piso_bit_source;

`ifdef PISO_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mon_en = 1'b0;
  always #5 clk = ~clk;

  piso_bit_source_if #(.WIDTH(8)) ifm ();
  piso_bit_source_if #(.WIDTH(8)) ifl ();

  piso_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk   (clk),
    .reset (reset),
    .bus   (ifm.slave)
  );

  piso_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk   (clk),
    .reset (reset),
    .bus   (ifl.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] sb_m[$];
  logic [1:0] sb_l[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {x, last} for each bit of one frame.
  task automatic push_frame(input logic [7:0] d, input bit lsb);
    logic b;
    logic lst;
    for (int k = 0; k < 8; k++) begin
      b   = lsb ? d[k] : d[7-k];
      lst = (k == 7) && (FLEN == 8);
      if (lsb) sb_l.push_back({b, lst});
      else     sb_m.push_back({b, lst});
    end
`ifdef PISO_PARITY_EN
    if (lsb) sb_l.push_back({^d, 1'b1});
    else     sb_m.push_back({^d, 1'b1});
`endif
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ifm.bit_valid !== 1'b0) begin
        if (sb_m.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL msb_unexpected_bit: got x=%b valid=%b expected no valid bit at %0t", ifm.x, ifm.bit_valid, $time);
        end else begin
          chk("msb_bit", 32'({ifm.x, ifm.last}), 32'(sb_m.pop_front()));
        end
      end
      if (ifl.bit_valid !== 1'b0) begin
        if (sb_l.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL lsb_unexpected_bit: got x=%b valid=%b expected no valid bit at %0t", ifl.x, ifl.bit_valid, $time);
        end else begin
          chk("lsb_bit", 32'({ifl.x, ifl.last}), 32'(sb_l.pop_front()));
        end
      end
    end
  end

  task automatic chk_idle_m(input string name);
    chk({name, "_x"},     32'(ifm.x),         32'd0);
    chk({name, "_valid"}, 32'(ifm.bit_valid), 32'd0);
    chk({name, "_last"},  32'(ifm.last),      32'd0);
    chk({name, "_ready"}, 32'(ifm.ready),     32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifm.load = 1'b0; ifm.din = '0;
    ifl.load = 1'b0; ifl.din = '0;
    reset = 1'b1;
    repeat (2) tick();
    chk_idle_m("reset");
    chk("reset_lsb_valid", 32'(ifl.bit_valid), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single frame; din changes after acceptance must not matter.
    ifm.din = 8'hAA; ifm.load = 1'b1; push_frame(8'hAA, 1'b0);
    tick();
    ifm.load = 1'b0; ifm.din = 8'h55;
    chk("t1_first_valid", 32'(ifm.bit_valid), 32'd1);
    chk("t1_busy_ready", 32'(ifm.ready), 32'd0);
    repeat (FLEN - 1) tick();
    chk("t1_last", 32'(ifm.last), 32'd1);
    chk("t1_last_ready", 32'(ifm.ready), 32'd1);
    tick();
    chk_idle_m("t1_idle");

    // Back-to-back frames with the second load on the last bit.
    ifm.din = 8'hA5; ifm.load = 1'b1; push_frame(8'hA5, 1'b0);
    tick();
    ifm.load = 1'b0;
    repeat (FLEN - 1) tick();
    chk("t2_last1", 32'(ifm.last), 32'd1);
    ifm.din = 8'h0F; ifm.load = 1'b1; push_frame(8'h0F, 1'b0);
    tick();
    ifm.load = 1'b0;
    chk("t2_no_gap_valid", 32'(ifm.bit_valid), 32'd1);
    chk("t2_no_gap_ready", 32'(ifm.ready), 32'd0);
    repeat (FLEN - 1) tick();
    chk("t2_last2", 32'(ifm.last), 32'd1);
    tick();
    chk_idle_m("t2_idle");

    // Load while busy is ignored.
    ifm.din = 8'hFF; ifm.load = 1'b1; push_frame(8'hFF, 1'b0);
    tick();
    ifm.load = 1'b0;
    for (int k = 1; k <= FLEN; k++) begin
      chk($sformatf("t3_ready_bit%0d", k), 32'(ifm.ready), (k == FLEN) ? 32'd1 : 32'd0);
      if (k == 3) begin
        ifm.din = 8'h00; ifm.load = 1'b1;
      end
      tick();
      ifm.load = 1'b0;
    end
    chk_idle_m("t3_idle");
    tick();
    chk("t3_still_idle", 32'(ifm.bit_valid), 32'd0);

    // Reset mid-frame, then a clean frame.
    ifm.din = 8'hC3; ifm.load = 1'b1; push_frame(8'hC3, 1'b0);
    tick();
    ifm.load = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    sb_m.delete();
    chk_idle_m("t4_reset");
    reset = 1'b0;
    ifm.din = 8'h81; ifm.load = 1'b1; push_frame(8'h81, 1'b0);
    tick();
    ifm.load = 1'b0;
    repeat (FLEN) tick();
    chk_idle_m("t4_idle");

    // LSB-first instance.
    ifl.din = 8'h01; ifl.load = 1'b1; push_frame(8'h01, 1'b1);
    tick();
    ifl.load = 1'b0;
    repeat (FLEN - 1) tick();
    chk("t5_lsb_last", 32'(ifl.last), 32'd1);
    tick();
    chk("t5_lsb_idle_valid", 32'(ifl.bit_valid), 32'd0);
    chk("t5_lsb_idle_x", 32'(ifl.x), 32'd0);

    // Parity-sensitive words (plain frames when the trailer is disabled).
    ifm.din = 8'h07; ifm.load = 1'b1; push_frame(8'h07, 1'b0);
    tick();
    ifm.load = 1'b0;
    repeat (FLEN) tick();
    ifm.din = 8'h03; ifm.load = 1'b1; push_frame(8'h03, 1'b0);
    tick();
    ifm.load = 1'b0;
    repeat (FLEN) tick();
    chk_idle_m("t6_idle");

    tick();
    chk("sb_msb_drained", 32'(sb_m.size()), 32'd0);
    chk("sb_lsb_drained", 32'(sb_l.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_bit_source.md
Name: piso_bit_source

Overview:
- Parallel-in/serial-out bit-stream generator feeding the serial `x` input of the 1010 Mealy sequence detector.
- Accepts a WIDTH-bit word via a load/ready handshake and emits it one bit per clk.
- Holds an idle level between frames so the detector sees a defined line value.
- Supports back-to-back frames with no gap cycles.

Parameters:
- WIDTH, 8, number of data bits per frame; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first.
- IDLE_LEVEL, 0, value driven on x while no frame is active.

Ports:
- clk  input  1  system clock; all state changes on posedge clk.
- reset  input  1  synchronous, active-high reset, sampled on posedge clk.
- din  input  WIDTH  parallel word; captured only on an accepted load.
- load  input  1  request to start a frame with din.
- ready  output  1  combinational; block can accept load this cycle.
- x  output  1  registered serial data bit; connects to the detector's x.
- bit_valid  output  1  registered; x carries a frame bit this cycle.
- last  output  1  registered; high with the final bit of a frame.

Behaviour:
- Reset (reset=1 at posedge clk):
  - Next state IDLE.
  - x=IDLE_LEVEL, bit_valid=0, last=0.
  - Shift register and bit counter cleared.
  - Reset overrides a simultaneous load.
- States:
  - IDLE: bit_valid=0, x=IDLE_LEVEL.
  - SHIFT: one frame bit presented per cycle.
- Frame length: FLEN = WIDTH, or WIDTH+1 with the optional feature.
- Bit counter: width $clog2(FLEN+1); counts bits already presented in the current frame.
- ready = (state==IDLE) || (state==SHIFT && last==1).
- Accepted load = load && ready at posedge clk. On that edge:
  - din is captured.
  - First bit is driven on x with bit_valid=1 in the following cycle.
  - Latency: load edge to first bit valid = 1 cycle.
- Data bits and ordering:
  - Bit k (k=0..WIDTH-1) of a frame is din[WIDTH-1-k] when MSB_FIRST=1, din[k] otherwise.
  - One bit per cycle; no stalls inside a frame.
- last is high only in the cycle the final frame bit is on x.
- Frame end, no accepted load on the last-bit edge:
  - Return to IDLE.
  - Next cycle x=IDLE_LEVEL, bit_valid=0.
- Frame end with an accepted load on the last-bit edge:
  - Stay in SHIFT.
  - Next cycle carries the first bit of the new word; zero gap cycles.
- load while ready=0: ignored; din is not captured and nothing is queued.
- din changing after an accepted load has no effect on the frame in flight.
- Reset mid-frame: frame discarded; outputs at reset values the next cycle; no partial last pulse.
- x and bit_valid never go X after reset.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra bit is sent: even parity = XOR of all captured din bits.
  - FLEN = WIDTH+1.
  - last is asserted with the parity bit, not the final data bit.
  - ready timing follows the new last.
- Undefined: no parity logic; FLEN = WIDTH; last is asserted with the final data bit.

Test Plan:
- Single frame, WIDTH=8, MSB_FIRST=1, din=8'b1010_1010, load one cycle:
  - Starting the cycle after load, x = 1,0,1,0,1,0,1,0 with bit_valid=1 for exactly 8 cycles.
  - last=1 only on the 8th bit.
  - Then x=0, bit_valid=0.
  - Downstream detector reports found on bits 4, 6 and 8 (overlapping matches).
- Back-to-back frames: load 8'hA5, then load 8'h0F while last=1:
  - 16 contiguous valid bits: 1010_0101_0000_1111.
  - last on bits 8 and 16; no idle cycle between frames.
- Load while busy: load 8'hFF accepted; load 8'h00 pulsed on bit 3:
  - Stream stays 1111_1111.
  - Second word is never transmitted.
  - ready=0 during bits 1-7.
- Reset mid-frame: load 8'hC3; assert reset for one cycle after bit 3:
  - Next cycle x=0, bit_valid=0, last=0, ready=1.
  - A fresh load 8'h81 then transmits 1000_0001 cleanly.
- LSB-first: MSB_FIRST=0, din=8'h01 -> x = 1,0,0,0,0,0,0,0.
- With PISO_PARITY_EN: din=8'h07 -> 9 valid bits 0000_0111 then parity 1, with last on the 9th bit; din=8'h03 -> parity bit 0.
